// File: rtl/frontend_pkg.sv
// Shared frontend types: fetch FSM states, architectural widths and a PC alignment helper.
package frontend_pkg;

   localparam int XLEN       = 32;
   localparam int INST_BYTES = 4;

   typedef logic [XLEN-1:0] addr_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH
   } fetch_state_t;

   // Instructions are word aligned, so the low address bits of a target are dropped.
   function automatic addr_t align_pc(input addr_t pc);
      return pc & ~addr_t'(INST_BYTES - 1);
   endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-side bus: request path to instruction memory and push/flush/pop path to the instruction queue.
interface fetch_controller_if;
   import frontend_pkg::*;

   logic  mem_req_out;
   addr_t mem_addr_out;
   addr_t mem_data_in;
   logic  iq_valid_out;
   addr_t iq_instruction_out;
   logic  iq_flush_out;
   logic  iq_pop_in;

   modport master (
      output mem_req_out, mem_addr_out, iq_valid_out, iq_instruction_out, iq_flush_out,
      input  mem_data_in, iq_pop_in
   );

   modport slave (
      input  mem_req_out, mem_addr_out, iq_valid_out, iq_instruction_out, iq_flush_out,
      output mem_data_in, iq_pop_in
   );

endinterface

// File: rtl/fetch_resp_pipe.sv
// Valid-only shift register that tracks outstanding memory reads; a clear kills every read in flight.
module fetch_resp_pipe #(
   parameter int DEPTH = 2
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic clear_in,
   input  logic valid_in,
   output logic valid_out
);

   logic [DEPTH-1:0] stage;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         stage <= '0;
      end else if (clear_in) begin
         stage <= '0;
      end else begin
         stage[0] <= valid_in;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign valid_out = stage[DEPTH-1];

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, issues credit-limited pipelined reads and
// forwards returned words to the instruction queue, flushing on branch redirects.
module fetch_controller
   import frontend_pkg::*;
#(
   parameter int    QUEUE_SIZE  = 4,
   parameter int    MEM_LATENCY = 2,
   parameter addr_t BOOT_PC     = 32'h0000_0000
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                start_in,
   input  logic                halt_in,
   input  logic                redirect_valid_in,
   input  addr_t               redirect_pc_in,
   output logic                busy_out,
   fetch_controller_if.master  bus
);

   localparam int CREDIT_W = $clog2(QUEUE_SIZE + 1);
   typedef logic [CREDIT_W-1:0] credit_t;

   fetch_state_t state, state_next;
   addr_t        pc, pc_next;
   credit_t      credits, credits_next;
   logic         issue;
   logic         resp_valid;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state   <= IDLE;
         pc      <= BOOT_PC;
         credits <= credit_t'(QUEUE_SIZE);
      end else begin
         state   <= state_next;
         pc      <= pc_next;
         credits <= credits_next;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      issue        = (state == RUN) && (credits != '0) && !redirect_valid_in;
      state_next   = state;
      pc_next      = pc;
      credits_next = credits - credit_t'(issue) + credit_t'(bus.iq_pop_in);

      unique case (state)
         IDLE:    if (start_in && !halt_in) state_next = RUN;
         RUN:     if (halt_in) state_next = IDLE;
         FLUSH:   state_next = RUN;
         default: state_next = IDLE;
      endcase

      if (issue) begin
         pc_next = pc + addr_t'(INST_BYTES);
      end

      // A redirect overrides halt/start and reclaims every credit held by killed reads or flushed entries.
      if (redirect_valid_in) begin
         state_next   = FLUSH;
         pc_next      = align_pc(redirect_pc_in);
         credits_next = credit_t'(QUEUE_SIZE);
      end
   end

   fetch_resp_pipe #(
      .DEPTH (MEM_LATENCY)
   ) u_resp_pipe (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .clear_in  (redirect_valid_in),
      .valid_in  (issue),
      .valid_out (resp_valid)
   );

   assign bus.mem_req_out        = issue;
   assign bus.mem_addr_out       = pc;
   assign bus.iq_valid_out       = resp_valid && !redirect_valid_in && (state != FLUSH);
   assign bus.iq_instruction_out = bus.mem_data_in;
   assign bus.iq_flush_out       = (state == FLUSH);
   assign busy_out               = (state != IDLE);

   credit_bound_a: assert property (@(posedge clk_in) disable iff (rst_in)
      credits <= credit_t'(QUEUE_SIZE));

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: a cycle reference model predicts requests and pushes,
// a small memory model answers the DUT's real requests after the fixed latency.
module tb_fetch_controller;
   import frontend_pkg::*;

   localparam int    QS   = 4;
   localparam int    LAT  = 2;
   localparam addr_t BOOT = 32'h0000_0000;

   logic  clk_in            = 1'b0;
   logic  rst_in            = 1'b0;
   logic  start_in          = 1'b0;
   logic  halt_in           = 1'b0;
   logic  redirect_valid_in = 1'b0;
   addr_t redirect_pc_in    = '0;
   logic  busy_out;

   fetch_controller_if bus ();

   fetch_controller #(
      .QUEUE_SIZE  (QS),
      .MEM_LATENCY (LAT),
      .BOOT_PC     (BOOT)
   ) dut (
      .clk_in            (clk_in),
      .rst_in            (rst_in),
      .start_in          (start_in),
      .halt_in           (halt_in),
      .redirect_valid_in (redirect_valid_in),
      .redirect_pc_in    (redirect_pc_in),
      .busy_out          (busy_out),
      .bus               (bus)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int    due;
      addr_t word;
   } resp_t;

   int           n_vectors     = 0;
   int           n_miscompares = 0;
   int           cyc           = 0;
   int           n_req         = 0;
   int           occ           = 0;
   bit           pop_en        = 1'b0;
   fetch_state_t m_state;
   addr_t        m_pc;
   int           m_credits;
   resp_t        sb[$];
   logic         hist_v[LAT];
   addr_t        hist_a[LAT];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vectors++;
      if (got !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic addr_t mem_word(input addr_t a);
      return a ^ 32'h5A5A_C3C3;
   endfunction

   task automatic model_reset();
      m_state   = IDLE;
      m_pc      = BOOT;
      m_credits = QS;
      occ       = 0;
      sb.delete();
      for (int i = 0; i < LAT; i++) begin
         hist_v[i] = 1'b0;
         hist_a[i] = '0;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_req"}, bus.mem_req_out, 1'b0);
      check({tag, "_mem_addr"}, bus.mem_addr_out, BOOT);
      check({tag, "_iq_valid"}, bus.iq_valid_out, 1'b0);
      check({tag, "_iq_flush"}, bus.iq_flush_out, 1'b0);
      check({tag, "_busy"}, busy_out, 1'b0);
   endtask

   // Called at the falling edge: compare this cycle's outputs, then advance the model.
   task automatic monitor();
      logic exp_issue;
      logic exp_valid;
      if (rst_in) model_reset();
      exp_issue = (m_state == RUN) && (m_credits != 0) && !redirect_valid_in;
      if (redirect_valid_in) sb.delete();
      exp_valid = (sb.size() > 0) && (sb[0].due == cyc);

      check("mem_req", bus.mem_req_out, exp_issue);
      check("mem_addr", bus.mem_addr_out, m_pc);
      check("iq_flush", bus.iq_flush_out, m_state == FLUSH);
      check("busy", busy_out, m_state != IDLE);
      check("iq_valid", bus.iq_valid_out, exp_valid);
      if (exp_valid) begin
         check("iq_instr", bus.iq_instruction_out, sb[0].word);
         void'(sb.pop_front());
      end
      if (bus.mem_req_out) n_req++;

      if (redirect_valid_in || rst_in) occ = 0;
      else occ = occ + int'(bus.iq_valid_out) - int'(bus.iq_pop_in);
      check("iq_occupancy_bound", occ <= QS, 1'b1);

      if (!rst_in) begin
         if (exp_issue) begin
            sb.push_back('{due: cyc + LAT, word: mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
         end
         m_credits = m_credits - int'(exp_issue) + int'(bus.iq_pop_in);
         case (m_state)
            IDLE:    if (start_in && !halt_in) m_state = RUN;
            RUN:     if (halt_in) m_state = IDLE;
            FLUSH:   m_state = RUN;
            default: m_state = IDLE;
         endcase
         if (redirect_valid_in) begin
            m_state   = FLUSH;
            m_pc      = redirect_pc_in & ~32'h3;
            m_credits = QS;
         end
      end

      for (int i = LAT - 1; i > 0; i--) begin
         hist_v[i] = hist_v[i-1];
         hist_a[i] = hist_a[i-1];
      end
      hist_v[0] = bus.mem_req_out && !rst_in;
      hist_a[0] = bus.mem_addr_out;
      cyc++;
   endtask

   task automatic tick(input logic rst, input logic start, input logic halt,
                       input logic redir, input addr_t rpc);
      @(posedge clk_in);
      #1;
      rst_in            = rst;
      start_in          = start;
      halt_in           = halt;
      redirect_valid_in = redir;
      redirect_pc_in    = rpc;
      bus.iq_pop_in     = pop_en && (occ > 0) && !redir && (m_state != FLUSH) && !rst;
      bus.mem_data_in   = hist_v[LAT-1] ? mem_word(hist_a[LAT-1]) : 32'hDEAD_BEEF;
      @(negedge clk_in);
      monitor();
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.iq_pop_in   = 1'b0;
      bus.mem_data_in = '0;
      model_reset();

      // Power-on reset is asynchronous: outputs settle before any clock edge.
      #1 rst_in = 1'b1;
      #1 check_reset_outputs("por");
      repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
      idle(1);

      // Fill with no pops: exactly QS requests, then stall on credits.
      n_req = 0;
      tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
      idle(10);
      check("fill_req_count", n_req, QS);

      // Steady popping keeps one request per cycle.
      pop_en = 1'b1;
      n_req  = 0;
      idle(12);
      check("steady_req_count", n_req >= 10, 1'b1);

      // Redirect with reads in flight; low address bits dropped.
      tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0103);
      idle(6);

      // Back-to-back redirects extend the flush.
      tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
      tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300);
      idle(6);

      // Halt, start+halt together stays idle, restart, then redirect from idle.
      tick(1'b0, 1'b0, 1'b1, 1'b0, '0);
      idle(3);
      tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
      idle(2);
      tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
      idle(4);
      tick(1'b0, 1'b0, 1'b1, 1'b0, '0);
      tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
      idle(6);

      // PC wraps past the top of the address space.
      tick(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      idle(8);

      // Asynchronous reset mid-cycle with reads in flight.
      @(posedge clk_in);
      #3 rst_in = 1'b1;
      #1 check_reset_outputs("async_rst");
      model_reset();
      repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
      idle(5);
      tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
      idle(8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
